sequence_checker: RTL and testbench
===================================

Name: sequence_checker

Overview:
Receive-side checker for the 4-bit repeating sequence 5,4,7,6,1,0,3,2, where value = index XOR 4'b0101 and index is 0..7. The checker samples a Number stream qualified by Valid and hunts for sequence alignment. It declares lock after a run of consecutive correct values and then flags every deviation. It sits downstream of the sequence generator and reports link health to test and status logic.

Parameters:
LOCK_COUNT, 3, consecutive in-order samples (seed included) required to enter LOCKED; legal range 2..8
LOSS_COUNT, 2, consecutive mismatches while LOCKED that drop back to HUNT; legal range 1..8
ERR_W, 8, width of the saturating error counter

Ports:
CLK  in  1  clock
Reset  in  1  synchronous, active-high reset
Valid  in  1  Number is sampled on rising CLK when high
Number  in  4  received sequence value
Locked  out  1  high while FSM is in LOCKED
Error  out  1  one-cycle pulse on each mismatching sample while LOCKED
Index  out  3  index of the last sample accepted as in-sequence
ErrCount  out  ERR_W  saturating count of Error pulses since reset
Wraps  out  8  wrapping count of index-7 matches while LOCKED

Behaviour:
- Reset (sync, active-high, priority over everything): state=HUNT, Locked=0, Error=0, Index=0, ErrCount=0, Wraps=0, expected index=0, run/miss counters=0.
- All outputs are registered. An effect appears one cycle after the sampling edge.
- Valid=0: no state change. Error is 0 on that cycle.
- Decode: a sample is well-formed only if Number[3]=0. Its index is Number[2:0] XOR 3'b101. A sample with Number[3]=1 is always a mismatch and never seeds.
- HUNT: on a well-formed sample, load expected=idx+1 (mod 8), Index=idx, run=1, go to VERIFY. A malformed sample stays in HUNT.
- VERIFY:
  - Match (idx==expected): run++, Index=idx, expected++. If run reaches LOCK_COUNT, go to LOCKED and set Locked=1 on that edge.
  - Mismatch: re-seed from this sample as in HUNT (run=1) if well-formed; otherwise go to HUNT. No Error pulse and no ErrCount change in VERIFY.
- LOCKED:
  - Match: Index=idx, expected++, miss=0. If idx==7, Wraps++ (8-bit wrap).
  - Mismatch: Error=1 for one cycle, ErrCount++ saturating at all-ones, miss++. Expected still advances (flywheel). Index is held.
  - When miss reaches LOSS_COUNT: go to HUNT, Locked=0, miss=0. The Error pulse for that sample is still issued.
- Expected index wraps 7->0 modulo 8. There is no special case at the wrap.
- A generator reset mid-stream (the stream jumps to 5) is an ordinary mismatch unless expected==0.
- Back-to-back Valid every cycle must be sustained with no bubbles.

Decomposition:
- Shared package seq_pkg holds:
  - SEQ_KEY = 4'b0101
  - SEQ_LEN = 8
  - state encoding HUNT=2'd0, VERIFY=2'd1, LOCKED=2'd2
  - function seq_value(idx) returning {1'b0, idx^3'b101}
- The generator must take SEQ_KEY from the same package.
- One sub-module, sat_counter (parameter width, inc, sync clear, saturate at max), used for ErrCount.
- Run and miss counters stay inline.

Test Plan:
- Reset, then Valid every cycle with 5,4,7 -> Locked rises 1 cycle after the sample 7; Index=2; Error never asserted; ErrCount=0.
- Locked, then 8 more in-order samples 6,1,0,3,2,5,4,7 -> Wraps=1 after the sample 2; Index tracks 3,4,5,6,7,0,1,2.
- Locked at Index=3, then inject 9 (malformed) followed by 0 -> Error pulse on the 9 only; ErrCount=1; Index holds 3 then becomes 5; Locked stays 1.
- Locked, then two consecutive wrong values 5,5 where 1,0 are expected -> two Error pulses; ErrCount=2; Locked=0 after the second. Then 5,4,7 -> relock.
- Start mid-sequence with 3,2,5 with Valid toggling every other cycle -> Locked after the sample 5, Index=0. Idle cycles cause no change.
- Assert Reset while LOCKED with ErrCount=4 -> next cycle all outputs are 0 and state is HUNT. Also drive 300 mismatch/relock cycles -> ErrCount saturates at 255.

Source files
------------

// File: rtl/seq_pkg.sv
// seq_pkg
// Shared definitions for the 4-bit repeating sequence 5,4,7,6,1,0,3,2.
// Each value is its index (0..7) XORed with SEQ_KEY. The generator and the
// checker both import this package, so they always agree on the key.
//
// Contents:
//   SEQ_KEY      - XOR key applied to the index to form a sequence value
//   SEQ_LEN      - number of distinct values in one period of the sequence
//   IDX_W        - width of a sequence index
//   seq_state_e  - checker FSM state encoding
//   seq_value()  - index -> on-the-wire value
//   seq_index()  - on-the-wire value -> index (ignores bit 3)
package seq_pkg;

  localparam logic [3:0] SEQ_KEY = 4'b0101;
  localparam int         SEQ_LEN = 8;
  localparam int         IDX_W   = $clog2(SEQ_LEN);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } seq_state_e;

  // Value transmitted for a given index; bit 3 is always clear.
  function automatic logic [3:0] seq_value(input logic [IDX_W-1:0] idx);
    return {1'b0, idx ^ SEQ_KEY[IDX_W-1:0]};
  endfunction

  // Index carried by a received value; only meaningful when bit 3 is clear.
  function automatic logic [IDX_W-1:0] seq_index(input logic [3:0] value);
    return value[IDX_W-1:0] ^ SEQ_KEY[IDX_W-1:0];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//
// Parameters:
//   WIDTH  counter width (2 or more)
// Ports:
//   CLK    in   clock
//   Reset  in   synchronous, active-high reset (clears the count)
//   clr    in   synchronous clear, lower priority than Reset
//   inc    in   count up by one unless already saturated
//   count  out  current count (registered)
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MAX  = {WIDTH{1'b1}};

  // Saturating count register with reset and clear.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      count <= ZERO;
    end else if (clr) begin
      count <= ZERO;
    end else if (inc && (count != MAX)) begin
      count <= count + ONE;
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/sequence_checker.sv
// sequence_checker
// Receive-side checker for the keyed 8-value sequence. Hunts for alignment,
// declares lock after LOCK_COUNT consecutive in-order samples (seed included)
// and then flags every deviation. LOSS_COUNT consecutive misses while locked
// send it back to hunting. While locked the expected index keeps advancing
// on a miss (flywheel), so a single corrupted sample does not lose alignment.
//
// Parameters:
//   LOCK_COUNT  in-order samples needed to lock (2..8)
//   LOSS_COUNT  consecutive misses that drop lock (1..8)
//   ERR_W       width of the saturating error counter
// Ports:
//   CLK       in   clock
//   Reset     in   synchronous, active-high reset
//   Valid     in   Number is sampled on the rising edge when high
//   Number    in   received sequence value (4 bits)
//   Locked    out  high while locked
//   Error     out  one-cycle pulse for each mismatch seen while locked
//   Index     out  index of the last sample accepted as in-sequence
//   ErrCount  out  saturating count of Error pulses since reset
//   Wraps     out  wrapping count of index-7 matches while locked
module sequence_checker
  import seq_pkg::*;
#(
  parameter int LOCK_COUNT = 3,
  parameter int LOSS_COUNT = 2,
  parameter int ERR_W      = 8
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Valid,
  input  logic [3:0]       Number,
  output logic             Locked,
  output logic             Error,
  output logic [2:0]       Index,
  output logic [ERR_W-1:0] ErrCount,
  output logic [7:0]       Wraps
);

  localparam logic [3:0]       LOCK_TGT = 4'(LOCK_COUNT);
  localparam logic [3:0]       LOSS_TGT = 4'(LOSS_COUNT);
  localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] IDX_LAST = {IDX_W{1'b1}};

  seq_state_e       state_r;
  logic [IDX_W-1:0] expected_r;
  logic [3:0]       run_r;
  logic [3:0]       miss_r;

  logic             well_formed_s;
  logic [IDX_W-1:0] idx_s;
  logic             match_s;
  logic             err_fire_s;

  // Decode the incoming sample against the expected position. Comparing the
  // whole 4-bit value means a sample with bit 3 set can never match.
  always_comb begin
    well_formed_s = 1'b0;
    idx_s         = {IDX_W{1'b0}};
    match_s       = 1'b0;
    err_fire_s    = 1'b0;
    well_formed_s = ~Number[3];
    idx_s         = seq_index(Number);
    match_s       = (Number == seq_value(expected_r));
    if (Valid && (state_r == LOCKED)) begin
      err_fire_s = ~match_s;
    end else begin
      err_fire_s = 1'b0;
    end
  end

  // Alignment FSM with registered Locked/Error/Index/Wraps outputs.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_r    <= HUNT;
      expected_r <= {IDX_W{1'b0}};
      run_r      <= 4'd0;
      miss_r     <= 4'd0;
      Locked     <= 1'b0;
      Error      <= 1'b0;
      Index      <= 3'd0;
      Wraps      <= 8'd0;
    end else begin
      Error <= 1'b0;
      if (Valid) begin
        case (state_r)
          HUNT: begin
            if (well_formed_s) begin
              expected_r <= idx_s + IDX_ONE;
              Index      <= idx_s;
              run_r      <= 4'd1;
              state_r    <= VERIFY;
            end else begin
              state_r <= HUNT;
            end
          end

          VERIFY: begin
            if (match_s) begin
              Index      <= idx_s;
              expected_r <= expected_r + IDX_ONE;
              if ((run_r + 4'd1) >= LOCK_TGT) begin
                run_r   <= 4'd0;
                miss_r  <= 4'd0;
                Locked  <= 1'b1;
                state_r <= LOCKED;
              end else begin
                run_r <= run_r + 4'd1;
              end
            end else if (well_formed_s) begin
              // Mismatch that could itself be a sequence start: re-seed.
              expected_r <= idx_s + IDX_ONE;
              Index      <= idx_s;
              run_r      <= 4'd1;
            end else begin
              run_r   <= 4'd0;
              state_r <= HUNT;
            end
          end

          LOCKED: begin
            // Flywheel: the expected position advances on hit and miss alike.
            expected_r <= expected_r + IDX_ONE;
            if (match_s) begin
              Index  <= idx_s;
              miss_r <= 4'd0;
              if (idx_s == IDX_LAST) begin
                Wraps <= Wraps + 8'd1;
              end else begin
                Wraps <= Wraps;
              end
            end else begin
              Error <= 1'b1;
              if ((miss_r + 4'd1) >= LOSS_TGT) begin
                miss_r  <= 4'd0;
                run_r   <= 4'd0;
                Locked  <= 1'b0;
                state_r <= HUNT;
              end else begin
                miss_r <= miss_r + 4'd1;
              end
            end
          end

          default: begin
            run_r   <= 4'd0;
            miss_r  <= 4'd0;
            Locked  <= 1'b0;
            state_r <= HUNT;
          end
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

  sat_counter #(
    .WIDTH (ERR_W)
  ) u_err_cnt (
    .CLK   (CLK),
    .Reset (Reset),
    .clr   (1'b0),
    .inc   (err_fire_s),
    .count (ErrCount)
  );

endmodule

// File: tb/tb_sequence_checker.sv
// Directed bench for sequence_checker. Each stimulus step pushes the outputs
// expected after the next rising edge; a monitor pops and compares them one
// time unit after that edge.
module tb_sequence_checker;

  logic       CLK;
  logic       Reset;
  logic       Valid;
  logic [3:0] Number;
  logic       Locked;
  logic       Error;
  logic [2:0] Index;
  logic [7:0] ErrCount;
  logic [7:0] Wraps;

  typedef struct {
    int         step_no;
    logic       locked;
    logic       error;
    logic [2:0] index;
    logic [7:0] errcount;
    logic [7:0] wraps;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_cnt = 0;
  int   sat_errs = 0;

  sequence_checker #(
    .LOCK_COUNT (3),
    .LOSS_COUNT (2),
    .ERR_W      (8)
  ) dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .Valid    (Valid),
    .Number   (Number),
    .Locked   (Locked),
    .Error    (Error),
    .Index    (Index),
    .ErrCount (ErrCount),
    .Wraps    (Wraps)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Monitor: compare DUT outputs with the oldest pending expectation.
  always @(posedge CLK) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if ((Locked !== e.locked) || (Error !== e.error) || (Index !== e.index) ||
          (ErrCount !== e.errcount) || (Wraps !== e.wraps)) begin
        errors++;
        $display("FAIL step%0d: got L=%0b E=%0b I=%0d EC=%0d W=%0d, want L=%0b E=%0b I=%0d EC=%0d W=%0d",
                 e.step_no, Locked, Error, Index, ErrCount, Wraps,
                 e.locked, e.error, e.index, e.errcount, e.wraps);
      end
    end
  end

  task automatic step(input logic r, input logic v, input logic [3:0] n,
                      input logic el, input logic ee, input logic [2:0] ei,
                      input logic [7:0] eec, input logic [7:0] ew);
    exp_t e;
    @(posedge CLK);
    #2;
    Reset  = r;
    Valid  = v;
    Number = n;
    step_cnt++;
    e.step_no  = step_cnt;
    e.locked   = el;
    e.error    = ee;
    e.index    = ei;
    e.errcount = eec;
    e.wraps    = ew;
    exp_q.push_back(e);
  endtask

  function automatic logic [7:0] sat8(input int n);
    return (n > 255) ? 8'd255 : n[7:0];
  endfunction

  initial begin
    Reset  = 1'b1;
    Valid  = 1'b0;
    Number = 4'd0;

    // Reset state
    step(1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 3'd0, 8'd0, 8'd0);
    // Acquire: 5,4,7 -> lock after 7
    step(1'b0, 1'b1, 4'd5,  1'b0, 1'b0, 3'd0, 8'd0, 8'd0);
    step(1'b0, 1'b1, 4'd4,  1'b0, 1'b0, 3'd1, 8'd0, 8'd0);
    step(1'b0, 1'b1, 4'd7,  1'b1, 1'b0, 3'd2, 8'd0, 8'd0);
    // Eight in-order samples; wrap counted on value 2 (index 7)
    step(1'b0, 1'b1, 4'd6,  1'b1, 1'b0, 3'd3, 8'd0, 8'd0);
    step(1'b0, 1'b1, 4'd1,  1'b1, 1'b0, 3'd4, 8'd0, 8'd0);
    step(1'b0, 1'b1, 4'd0,  1'b1, 1'b0, 3'd5, 8'd0, 8'd0);
    step(1'b0, 1'b1, 4'd3,  1'b1, 1'b0, 3'd6, 8'd0, 8'd0);
    step(1'b0, 1'b1, 4'd2,  1'b1, 1'b0, 3'd7, 8'd0, 8'd1);
    step(1'b0, 1'b1, 4'd5,  1'b1, 1'b0, 3'd0, 8'd0, 8'd1);
    step(1'b0, 1'b1, 4'd4,  1'b1, 1'b0, 3'd1, 8'd0, 8'd1);
    step(1'b0, 1'b1, 4'd7,  1'b1, 1'b0, 3'd2, 8'd0, 8'd1);
    // Index 3, then malformed 9, then 0 (flywheel keeps alignment)
    step(1'b0, 1'b1, 4'd6,  1'b1, 1'b0, 3'd3, 8'd0, 8'd1);
    step(1'b0, 1'b1, 4'd9,  1'b1, 1'b1, 3'd3, 8'd1, 8'd1);
    step(1'b0, 1'b1, 4'd0,  1'b1, 1'b0, 3'd5, 8'd1, 8'd1);

    // Loss of lock after two misses, then relock
    step(1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 3'd0, 8'd0, 8'd0);
    step(1'b0, 1'b1, 4'd5,  1'b0, 1'b0, 3'd0, 8'd0, 8'd0);
    step(1'b0, 1'b1, 4'd4,  1'b0, 1'b0, 3'd1, 8'd0, 8'd0);
    step(1'b0, 1'b1, 4'd7,  1'b1, 1'b0, 3'd2, 8'd0, 8'd0);
    step(1'b0, 1'b1, 4'd6,  1'b1, 1'b0, 3'd3, 8'd0, 8'd0);
    step(1'b0, 1'b0, 4'd1,  1'b1, 1'b0, 3'd3, 8'd0, 8'd0);
    step(1'b0, 1'b1, 4'd5,  1'b1, 1'b1, 3'd3, 8'd1, 8'd0);
    step(1'b0, 1'b1, 4'd5,  1'b0, 1'b1, 3'd3, 8'd2, 8'd0);
    step(1'b0, 1'b1, 4'd5,  1'b0, 1'b0, 3'd0, 8'd2, 8'd0);
    step(1'b0, 1'b1, 4'd4,  1'b0, 1'b0, 3'd1, 8'd2, 8'd0);
    step(1'b0, 1'b1, 4'd7,  1'b1, 1'b0, 3'd2, 8'd2, 8'd0);

    // Mid-sequence start with Valid on every other cycle
    step(1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 3'd0, 8'd0, 8'd0);
    step(1'b0, 1'b1, 4'd3,  1'b0, 1'b0, 3'd6, 8'd0, 8'd0);
    step(1'b0, 1'b0, 4'd9,  1'b0, 1'b0, 3'd6, 8'd0, 8'd0);
    step(1'b0, 1'b1, 4'd2,  1'b0, 1'b0, 3'd7, 8'd0, 8'd0);
    step(1'b0, 1'b0, 4'd7,  1'b0, 1'b0, 3'd7, 8'd0, 8'd0);
    step(1'b0, 1'b1, 4'd5,  1'b1, 1'b0, 3'd0, 8'd0, 8'd0);
    step(1'b0, 1'b0, 4'd5,  1'b1, 1'b0, 3'd0, 8'd0, 8'd0);

    // Build ErrCount=4 while staying locked, then reset
    step(1'b0, 1'b1, 4'd5,  1'b1, 1'b1, 3'd0, 8'd1, 8'd0);
    step(1'b0, 1'b1, 4'd7,  1'b1, 1'b0, 3'd2, 8'd1, 8'd0);
    step(1'b0, 1'b1, 4'd5,  1'b1, 1'b1, 3'd2, 8'd2, 8'd0);
    step(1'b0, 1'b1, 4'd1,  1'b1, 1'b0, 3'd4, 8'd2, 8'd0);
    step(1'b0, 1'b1, 4'd5,  1'b1, 1'b1, 3'd4, 8'd3, 8'd0);
    step(1'b0, 1'b1, 4'd3,  1'b1, 1'b0, 3'd6, 8'd3, 8'd0);
    step(1'b0, 1'b1, 4'd5,  1'b1, 1'b1, 3'd6, 8'd4, 8'd0);
    step(1'b1, 1'b1, 4'd0,  1'b0, 1'b0, 3'd0, 8'd0, 8'd0);
    // Malformed samples never seed while hunting
    step(1'b0, 1'b1, 4'd8,  1'b0, 1'b0, 3'd0, 8'd0, 8'd0);
    step(1'b0, 1'b1, 4'd13, 1'b0, 1'b0, 3'd0, 8'd0, 8'd0);

    // Repeated lock / double-miss cycles until ErrCount saturates
    sat_errs = 0;
    for (int i = 0; i < 130; i++) begin
      step(1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 3'd0, sat8(sat_errs), 8'd0);
      step(1'b0, 1'b1, 4'd4, 1'b0, 1'b0, 3'd1, sat8(sat_errs), 8'd0);
      step(1'b0, 1'b1, 4'd7, 1'b1, 1'b0, 3'd2, sat8(sat_errs), 8'd0);
      sat_errs++;
      step(1'b0, 1'b1, 4'd5, 1'b1, 1'b1, 3'd2, sat8(sat_errs), 8'd0);
      sat_errs++;
      step(1'b0, 1'b1, 4'd5, 1'b0, 1'b1, 3'd2, sat8(sat_errs), 8'd0);
    end
    // Idle: counter stays pinned at all-ones
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 3'd2, 8'd255, 8'd0);

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 10; k++) begin
      if (exp_q.size() > 0) @(posedge CLK);
    end
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
